mdu_sequencer: RTL
==================

# mdu_sequencer

Iterative multiply/divide unit and its sequencer for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and runs a WIDTH-cycle shift-add multiply or restoring divide on operand magnitudes. It then applies sign correction and commits the HI/LO registers. While busy, it raises a stall request to the hazard logic for any Decode-stage instruction that touches HI/LO. It also owns the architectural HI/LO registers, including MTHI/MTLO writes from Writeback.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- startE  in  1  valid MDU op in E stage, already qualified by flushE
- opE  in  2  mdu_op_t: MULT, MULTU, DIV, DIVU
- srcaE  in  WIDTH  rs operand (multiplicand / dividend)
- srcbE  in  WIDTH  rt operand (multiplier / divisor)
- hiloD  in  1  D-stage instruction reads or writes HI/LO or is an MDU op
- hienW, loenW  in  1 each  MTHI/MTLO write enables
- wdataW  in  WIDTH  MTHI/MTLO data
- hi, lo  out  WIDTH each  architectural HI/LO registers
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO commit
- stallD  out  1  stall request to F/D stages

## Operation
- States: IDLE, RUN, FIX.
- IDLE -> RUN on startE. Latches op, the operand magnitudes, the result sign (sa^sb for quotient/product, sa for remainder), and count=0. Unsigned ops take magnitudes as-is.
- RUN, multiply: add multiplicand to the upper half if product LSB=1, then shift the 2·WIDTH product right.
- RUN, divide: restoring step; shift {rem,quot} left and trial-subtract the divisor; on no borrow, keep the difference and set quot LSB.
- count increments each RUN cycle; at count=WIDTH-1 go to FIX.
- FIX, multiply: negate the 2·WIDTH product if the sign flag is set.
- FIX, divide: negate the quotient if sa^sb; give the remainder the sign of the dividend.
- FIX commits hi/lo, pulses done, and returns to IDLE.
- Divide by zero: IDLE -> FIX directly, skipping RUN, for all divide variants. Result hi=srcaE, lo=all ones.
- Most-negative / -1 (DIV): lo=0x80000000, hi=0, with no trap.
- MULT(-2^(W-1), -2^(W-1)) yields the correct positive 2W-bit product.
- MTHI/MTLO: write hi/lo from wdataW when in IDLE. They are dropped while busy, which legal code cannot produce because of stallD.
- If startE coincides with hienW/loenW, the W write applies and the operation later overwrites both registers.
- startE while busy is ignored (protocol violation; stallD prevents it).
- stallD = hiloD & (busy | startE), combinational.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE; stallD follows its equation (0 when hiloD=0).
- Reset assertion mid-operation aborts immediately. hi/lo clear to 0 and no done pulse is issued.
- startE sampled in cycle t:
  - RUN occupies t+1..t+WIDTH.
  - FIX occupies t+WIDTH+1.
  - hi/lo are new and done=1 in t+WIDTH+2, i.e. cycle t+34 for WIDTH=32.
- busy=1 from t+1 through t+WIDTH+1.
- Divide by zero: FIX at t+1; result and done at t+2.
- done lasts exactly one cycle.
- hi/lo change only at FIX commit or an IDLE MTHI/MTLO.
- A D-stage MFHI in cycle t+WIDTH+2 does not stall and sees the new value.

## Structure
- Package mdu_pkg:
  - mdu_op_t enum: MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11
  - mdu_state_t enum: IDLE, RUN, FIX
  - MDU_WIDTH=32
- Single module, no sub-modules. The shared 2·WIDTH shift register serves both algorithms; one WIDTH+1-bit adder/subtractor is used for the iteration steps.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF at t=0 -> hi=0xFFFFFFFE, lo=0x00000001, done at t=34, busy t=1..33.
- MULT -3×7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/0 -> done at t=2, hi=100, lo=0xFFFFFFFF.
- hiloD=1 held from t=0 with start at t=0 -> stallD=1 for t=0..33, 0 at t=34. hiloD=0 -> stallD=0 throughout.
- MTLO 0x1234 in IDLE -> lo=0x1234 next cycle. MTHI while busy -> hi unchanged. MTHI and startE in the same cycle -> hi=wdata, then the product overwrites it.
- reset low at t=10 of a MULT -> hi=lo=0, busy=0 immediately, no done pulse. A new MULTU 6×7 after release -> lo=42.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   mdu_op_t    : MDU operation encoding delivered by the Execute stage
//   mdu_state_t : sequencer states
//   MDU_WIDTH   : operand width, which is also the iteration count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Iterative multiply/divide unit for the pipelined MIPS core. Runs a WIDTH-cycle
// shift-add multiply or restoring divide on operand magnitudes, fixes the sign,
// then commits the architectural HI/LO registers (also written by MTHI/MTLO).
//
// Ports:
//   clk            core clock, rising edge
//   reset          asynchronous, active-low; clears all state
//   startE         valid MDU op in E stage (already qualified by flush)
//   opE            mdu_op_t operation
//   srcaE, srcbE   rs / rt operands
//   hiloD          D-stage instruction touches HI/LO or is an MDU op
//   hienW, loenW   MTHI / MTLO write enables from Writeback
//   wdataW         MTHI / MTLO data
//   hi, lo         architectural HI/LO registers
//   busy           operation in flight
//   done           one-cycle pulse when HI/LO commit
//   stallD         stall request to F/D stages
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiloD,
    input  logic             hienW,
    input  logic             loenW,
    input  logic [WIDTH-1:0] wdataW,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stallD
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      count_q, count_d;
    logic               negQuot_q, negQuot_d;
    logic               negRem_q, negRem_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Incoming operand decode: signs only matter for MULT/DIV.
    mdu_op_t            opIn;
    logic               isDivIn;
    logic               signA, signB;
    logic [WIDTH-1:0]   magA, magB;

    assign opIn    = mdu_op_t'(opE);
    assign isDivIn = (opIn == DIV) || (opIn == DIVU);
    assign signA   = ((opIn == MULT) || (opIn == DIV)) && srcaE[WIDTH-1];
    assign signB   = ((opIn == MULT) || (opIn == DIV)) && srcbE[WIDTH-1];
    assign magA    = signA ? -srcaE : srcaE;
    assign magB    = signB ? -srcbE : srcbE;

    // Single shared adder/subtractor. Multiply adds the multiplicand to the
    // upper half; divide subtracts the divisor from the partial remainder
    // already shifted left by one (taken as prod[2W-1:W-1]). The extra top bit
    // of the sum is the borrow for the divide trial subtraction.
    logic               isDiv;
    logic [WIDTH:0]     addA, addB;
    logic [WIDTH+1:0]   addSum;
    logic               borrow;

    assign isDiv  = (op_q == DIV) || (op_q == DIVU);
    assign addA   = isDiv ? prod_q[2*WIDTH-1:WIDTH-1] : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    assign addB   = (isDiv || prod_q[0]) ? {1'b0, opnd_q} : '0;
    assign addSum = {1'b0, addA} + (isDiv ? ~{1'b0, addB} : {1'b0, addB})
                  + {{(WIDTH+1){1'b0}}, isDiv};
    assign borrow = addSum[WIDTH+1];

    // Sign-corrected results, used only in FIX.
    logic [2*WIDTH-1:0] mulRes;
    logic [WIDTH-1:0]   quotRes, remRes;

    assign mulRes  = negQuot_q ? -prod_q : prod_q;
    assign quotRes = negQuot_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign remRes  = negRem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

    // Next-state logic. A divide by zero preloads the final {hi,lo} pattern
    // and jumps straight to FIX, which then commits it unmodified.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        count_d   = count_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (hienW) hi_d = wdataW;
                if (loenW) lo_d = wdataW;
                if (startE) begin
                    op_d      = opIn;
                    negQuot_d = signA ^ signB;
                    negRem_d  = signA;
                    count_d   = '0;
                    divZero_d = 1'b0;
                    if (isDivIn && (srcbE == '0)) begin
                        prod_d    = {srcaE, {WIDTH{1'b1}}};
                        divZero_d = 1'b1;
                        state_d   = FIX;
                    end else if (isDivIn) begin
                        prod_d  = {{WIDTH{1'b0}}, magA};
                        opnd_d  = magB;
                        state_d = RUN;
                    end else begin
                        prod_d  = {{WIDTH{1'b0}}, magB};
                        opnd_d  = magA;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!isDiv) begin
                    prod_d = {addSum[WIDTH:0], prod_q[WIDTH-1:1]};
                end else if (!borrow) begin
                    prod_d = {addSum[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                end else begin
                    prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                if (divZero_q) begin
                    hi_d = prod_q[2*WIDTH-1:WIDTH];
                    lo_d = prod_q[WIDTH-1:0];
                end else if (isDiv) begin
                    hi_d = remRes;
                    lo_d = quotRes;
                end else begin
                    hi_d = mulRes[2*WIDTH-1:WIDTH];
                    lo_d = mulRes[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            prod_q    <= '0;
            opnd_q    <= '0;
            count_q   <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            count_q   <= count_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign stallD = hiloD & (busy | startE);

endmodule
